riscv_ascon_sequencer: RTL and testbench
========================================

RISCV_ASCON_SEQUENCER -- requirements
Module: riscv_ascon_sequencer

Interface
REQ-001 SHALL have parameter UNROLLED_ROUNDS, default 1, meaning Ascon rounds computed per clock cycle; legal values are 1, 2, 3, 4 and 6.
REQ-002 SHALL have parameter SWAP_ENDIANESS, default 1, meaning byte-swap each 32-bit register word on input and output when set to 1.
REQ-003 clk_i  input  1  system clock, one clock only, all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  a permutation request is offered.
REQ-006 req_ready_o  output  1  the sequencer accepts a request.
REQ-007 rounds_i  input  4  number of rounds a, sampled on request handshake.
REQ-008 state_i  input  320  ascon_state_t, input state x0..x4, sampled on request handshake.
REQ-009 resp_valid_o  output  1  the result is available.
REQ-010 resp_ready_i  input  1  the consumer takes the result.
REQ-011 state_o  output  320  ascon_state_t, result state.
REQ-012 err_o  output  1  qualifies the response: the round count was illegal.
REQ-013 busy_o  output  1  high in RUN and DONE.
REQ-014 perf_cnt_o  output  32  accumulated RUN cycles.

Function
REQ-015 FSM SHALL have states IDLE, RUN and DONE; req_ready_o=1 only in IDLE.
REQ-016 IDLE->RUN on req_valid_i&req_ready_o with legal rounds_i; the state register loads state_i (swapped per SWAP_ENDIANESS), the remaining-round counter loads rounds_i, and the constant index k loads 12-rounds_i.
REQ-017 Legal rounds_i: 1..12 and a multiple of UNROLLED_ROUNDS; otherwise IDLE->DONE directly, state_o=state_i unchanged, err_o=1.
REQ-018 Each RUN cycle SHALL apply UNROLLED_ROUNDS rounds; round j of the cycle uses constant {4'hF-(k+j), 4'(k+j)}; k += U and counter -= U (U = UNROLLED_ROUNDS).
REQ-019 RUN->DONE when the counter equals U; latency from accept to resp_valid_o=1 is exactly rounds_i/U cycles.
REQ-020 In DONE resp_valid_o=1; state_o (unswapped per SWAP_ENDIANESS) and err_o SHALL stay stable until resp_ready_i=1; DONE->IDLE on handshake.
REQ-021 No same-cycle response/request overlap: a new request is accepted no earlier than the cycle after the response handshake.
REQ-022 req_valid_i asserted in RUN/DONE SHALL be ignored (not consumed); rounds_i/state_i changes after acceptance have no effect.
REQ-023 state_o SHALL be driven 0 whenever resp_valid_o=0.

Reset
REQ-024 rst_ni low SHALL asynchronously force IDLE, state register 0, counters 0, resp_valid_o=0, err_o=0, busy_o=0, perf_cnt_o=0, req_ready_o=1 after release.
REQ-025 Reset during RUN or DONE SHALL discard the in-flight operation; no response is produced.

Configuration
REQ-026 Macro ASCON_PERF_CNT_EN defined: perf_cnt_o increments by 1 each RUN cycle, wraps 0xFFFFFFFF->0, cleared only by reset.
REQ-027 Macro ASCON_PERF_CNT_EN undefined: the counter is not built; perf_cnt_o is tied to 0.

Structure
REQ-028 ascon_state_t, SWAP_REG_ENDIANESS_FUNC, the FSM state enum and ASCON_MAX_ROUNDS=12 SHALL live in riscv_ascon_defines.
REQ-029 The single-round datapath (addition of constants, S-box, linear layer) SHALL be a sub-module riscv_ascon_round, instantiated UNROLLED_ROUNDS times in a chain.

Verification
REQ-030 U=1, zero state, rounds=12 -> resp_valid_o exactly 12 cycles after accept; state_o equals the golden C model p^12.
REQ-031 U=2, random state, rounds=6 then rounds=8 -> latencies 3 and 4 cycles; both results match the golden model.
REQ-032 rounds=0, rounds=13 and (U=4, rounds=6) -> resp_valid_o next cycle, err_o=1, state_o==state_i.
REQ-033 resp_ready_i held low 5 cycles in DONE -> state_o, err_o and resp_valid_o stable; req_ready_o=0 throughout.
REQ-034 rst_ni pulsed low in RUN cycle 3 -> outputs 0 immediately; the next request completes correctly and no stale response appears.
REQ-035 With ASCON_PERF_CNT_EN, two p^12 runs at U=1 -> perf_cnt_o=24; without the macro -> perf_cnt_o=0.

Source files
------------

// File: rtl/riscv_ascon_defines.sv
// Shared types and helpers for the Ascon permutation sequencer.
// State word xN sits at ascon_state_t[N], i.e. x0 in bits [63:0].
package riscv_ascon_defines;

  localparam int ASCON_MAX_ROUNDS = 12;

  typedef logic [4:0][63:0] ascon_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ascon_fsm_e;

  function automatic ascon_state_t SWAP_REG_ENDIANESS_FUNC(
    input ascon_state_t s
  );
    logic [319:0] w_in;
    logic [319:0] w_out;
    w_in  = s;
    w_out = '0;
    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < 4; b++) begin
        w_out[32*i+8*b +: 8] = w_in[32*i+8*(3-b) +: 8];
      end
    end
    return w_out;
  endfunction

  function automatic logic [63:0] ror64(
    input logic [63:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32'd64 - n));
  endfunction

endpackage

// File: rtl/riscv_ascon_round.sv
// One Ascon round: constant addition on x2, 5-bit S-box layer,
// then the per-word linear diffusion layer.
module riscv_ascon_round
  import riscv_ascon_defines::*;
(
  input  ascon_state_t i_state,
  input  logic [3:0]   i_idx,
  output ascon_state_t o_state
);

  localparam int unsigned R0 [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned R1 [5] = '{28, 39, 6, 17, 41};

  logic [7:0]   w_rc;
  ascon_state_t w_a;
  ascon_state_t w_b;
  ascon_state_t w_c;
  ascon_state_t w_d;
  ascon_state_t w_o;

  assign w_rc = {4'hF - i_idx, i_idx};

  assign w_a[0] = i_state[0];
  assign w_a[1] = i_state[1];
  assign w_a[2] = i_state[2] ^ {56'h0, w_rc};
  assign w_a[3] = i_state[3];
  assign w_a[4] = i_state[4];

  assign w_b[0] = w_a[0] ^ w_a[4];
  assign w_b[1] = w_a[1];
  assign w_b[2] = w_a[2] ^ w_a[1];
  assign w_b[3] = w_a[3];
  assign w_b[4] = w_a[4] ^ w_a[3];

  // chi-like core of the S-box, bitsliced over all 64 columns
  for (genvar i = 0; i < 5; i++) begin : g_chi
    assign w_c[i] = w_b[i] ^
                    (~w_b[(i+1)%5] & w_b[(i+2)%5]);
  end

  assign w_d[0] = w_c[0] ^ w_c[4];
  assign w_d[1] = w_c[1] ^ w_c[0];
  assign w_d[2] = ~w_c[2];
  assign w_d[3] = w_c[3] ^ w_c[2];
  assign w_d[4] = w_c[4];

  for (genvar i = 0; i < 5; i++) begin : g_lin
    assign w_o[i] = w_d[i] ^
                    ror64(w_d[i], R0[i]) ^
                    ror64(w_d[i], R1[i]);
  end

  assign o_state = w_o;

endmodule

// File: rtl/riscv_ascon_sequencer.sv
// Ascon p^a sequencer, UNROLLED_ROUNDS rounds per cycle.
// Optional run-cycle counter: define ASCON_PERF_CNT_EN.
module riscv_ascon_sequencer
  import riscv_ascon_defines::*;
#(
  parameter int unsigned UNROLLED_ROUNDS = 1,
  parameter int unsigned SWAP_ENDIANESS  = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [3:0]   rounds_i,
  input  ascon_state_t state_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output ascon_state_t state_o,
  output logic         err_o,
  output logic         busy_o,
  output logic [31:0]  perf_cnt_o
);

  localparam logic [3:0] LP_U = 4'(UNROLLED_ROUNDS);
  localparam logic [3:0] LP_MAX = 4'(ASCON_MAX_ROUNDS);

  ascon_fsm_e   r_fsm;
  ascon_fsm_e   w_fsm_nxt;
  ascon_state_t r_state;
  ascon_state_t w_state_nxt;
  ascon_state_t w_state_in;
  ascon_state_t w_state_out;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic [3:0]   r_k;
  logic [3:0]   w_k_nxt;
  logic         r_err;
  logic         w_err_nxt;
  logic         w_legal;
  ascon_state_t w_chain [UNROLLED_ROUNDS+1];

  if (SWAP_ENDIANESS == 1) begin : g_swap
    assign w_state_in  = SWAP_REG_ENDIANESS_FUNC(state_i);
    assign w_state_out = SWAP_REG_ENDIANESS_FUNC(r_state);
  end else begin : g_noswap
    assign w_state_in  = state_i;
    assign w_state_out = r_state;
  end

  assign w_legal = (rounds_i != 4'd0) &&
                   (rounds_i <= LP_MAX) &&
                   ((rounds_i % LP_U) == 4'd0);

  assign w_chain[0] = r_state;

  for (genvar j = 0; j < UNROLLED_ROUNDS; j++) begin : g_rnd
    riscv_ascon_round u_round (
      .i_state (w_chain[j]),
      .i_idx   (r_k + 4'(j)),
      .o_state (w_chain[j+1])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_k     <= w_k_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // an illegal round count skips RUN and echoes state_i back
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_k_nxt     = r_k;
    w_err_nxt   = r_err;
    unique case (r_fsm)
      IDLE: begin
        if (req_valid_i) begin
          w_state_nxt = w_state_in;
          w_err_nxt   = !w_legal;
          if (w_legal) begin
            w_fsm_nxt = RUN;
            w_cnt_nxt = rounds_i;
            w_k_nxt   = LP_MAX - rounds_i;
          end else begin
            w_fsm_nxt = DONE;
          end
        end
      end
      RUN: begin
        w_state_nxt = w_chain[UNROLLED_ROUNDS];
        w_k_nxt     = r_k + LP_U;
        w_cnt_nxt   = r_cnt - LP_U;
        if (r_cnt == LP_U) begin
          w_fsm_nxt = DONE;
        end
      end
      DONE: begin
        if (resp_ready_i) begin
          w_fsm_nxt = IDLE;
          w_err_nxt = 1'b0;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  assign req_ready_o  = (r_fsm == IDLE);
  assign resp_valid_o = (r_fsm == DONE);
  assign busy_o       = (r_fsm == RUN) ||
                        (r_fsm == DONE);
  assign state_o      = resp_valid_o ?
                        w_state_out : '0;
  assign err_o        = resp_valid_o & r_err;

`ifdef ASCON_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf <= '0;
    end else if (r_fsm == RUN) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cnt_o = r_perf;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_ascon_sequencer.sv
// Randomized bench for riscv_ascon_sequencer at U=1,2 (swapped)
// and U=4 (unswapped), against a table-driven Ascon model.
module tb_riscv_ascon_sequencer;

  localparam int NI = 3;
  localparam int UR [NI] = '{1, 2, 4};
  localparam bit SW [NI] = '{1'b1, 1'b1, 1'b0};
`ifdef ASCON_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid  [NI];
  logic         req_ready  [NI];
  logic         resp_valid [NI];
  logic         resp_ready [NI];
  logic         err        [NI];
  logic         busy       [NI];
  logic [3:0]   rounds     [NI];
  logic [319:0] st_in      [NI];
  logic [319:0] st_out     [NI];
  logic [31:0]  perf       [NI];

  int n_chk = 0;
  int n_fail = 0;
  int perf_exp [NI];

  always #5 clk = ~clk;

  riscv_ascon_sequencer #(
    .UNROLLED_ROUNDS (1),
    .SWAP_ENDIANESS  (1)
  ) u_dut0 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid[0]),
    .req_ready_o  (req_ready[0]),
    .rounds_i     (rounds[0]),
    .state_i      (st_in[0]),
    .resp_valid_o (resp_valid[0]),
    .resp_ready_i (resp_ready[0]),
    .state_o      (st_out[0]),
    .err_o        (err[0]),
    .busy_o       (busy[0]),
    .perf_cnt_o   (perf[0])
  );

  riscv_ascon_sequencer #(
    .UNROLLED_ROUNDS (2),
    .SWAP_ENDIANESS  (1)
  ) u_dut1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid[1]),
    .req_ready_o  (req_ready[1]),
    .rounds_i     (rounds[1]),
    .state_i      (st_in[1]),
    .resp_valid_o (resp_valid[1]),
    .resp_ready_i (resp_ready[1]),
    .state_o      (st_out[1]),
    .err_o        (err[1]),
    .busy_o       (busy[1]),
    .perf_cnt_o   (perf[1])
  );

  riscv_ascon_sequencer #(
    .UNROLLED_ROUNDS (4),
    .SWAP_ENDIANESS  (0)
  ) u_dut2 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid[2]),
    .req_ready_o  (req_ready[2]),
    .rounds_i     (rounds[2]),
    .state_i      (st_in[2]),
    .resp_valid_o (resp_valid[2]),
    .resp_ready_i (resp_ready[2]),
    .state_o      (st_out[2]),
    .err_o        (err[2]),
    .busy_o       (busy[2]),
    .perf_cnt_o   (perf[2])
  );

  task automatic check(
    input string        tag,
    input logic [319:0] got,
    input logic [319:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [319:0] bswap(input logic [319:0] s);
    logic [319:0] r;
    for (int w = 0; w < 10; w++) begin
      r[32*w +: 32] = {s[32*w +: 8], s[32*w+8 +: 8],
                       s[32*w+16 +: 8], s[32*w+24 +: 8]};
    end
    return r;
  endfunction

  function automatic logic [63:0] ror(
    input logic [63:0] v,
    input int          n
  );
    return (v >> n) | (v << (64 - n));
  endfunction

  // textbook Ascon: rounds first..11 of p^12, S-box by table
  function automatic logic [319:0] perm(
    input logic [319:0] s,
    input int           first
  );
    logic [63:0] x [5];
    logic [4:0]  v;
    for (int i = 0; i < 5; i++) x[i] = s[64*i +: 64];
    for (int r = first; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        x[0][b] = v[4];
        x[1][b] = v[3];
        x[2][b] = v[2];
        x[3][b] = v[1];
        x[4][b] = v[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1) ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7) ^ ror(x[4], 41);
    end
    for (int i = 0; i < 5; i++) s[64*i +: 64] = x[i];
    return s;
  endfunction

  task automatic model(
    input  int           d,
    input  logic [319:0] s,
    input  int           a,
    output logic [319:0] exp,
    output bit           e,
    output int           lat
  );
    logic [319:0] t;
    if (a >= 1 && a <= 12 && (a % UR[d]) == 0) begin
      t   = SW[d] ? bswap(s) : s;
      t   = perm(t, 12 - a);
      exp = SW[d] ? bswap(t) : t;
      e   = 1'b0;
      lat = a / UR[d];
    end else begin
      exp = s;
      e   = 1'b1;
      lat = 0;
    end
  endtask

  task automatic run_op(
    input int           d,
    input logic [3:0]   a,
    input logic [319:0] s,
    input int           hold
  );
    logic [319:0] exp;
    bit           e;
    int           lat_exp;
    int           lat;
    string        p;
    p = $sformatf("u%0d_r%0d_", UR[d], a);
    model(d, s, int'(a), exp, e, lat_exp);
    check({p, "req_ready"}, req_ready[d], 1);
    req_valid[d] = 1'b1;
    rounds[d]    = a;
    st_in[d]     = s;
    @(posedge clk);
    #1;
    // keep offering junk: it must be neither consumed nor sampled
    rounds[d] = 4'($urandom);
    st_in[d]  = rnd320();
    lat = 0;
    while (!resp_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({p, "latency"}, lat, lat_exp);
    check({p, "state"}, st_out[d], exp);
    check({p, "err"}, err[d], e);
    check({p, "busy"}, busy[d], 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({p, "hold_valid"}, resp_valid[d], 1);
      check({p, "hold_state"}, st_out[d], exp);
      check({p, "hold_err"}, err[d], e);
      check({p, "hold_ready"}, req_ready[d], 0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    check({p, "post_valid"}, resp_valid[d], 0);
    check({p, "post_busy"}, busy[d], 0);
    check({p, "post_state"}, st_out[d], 0);
    check({p, "post_err"}, err[d], 0);
    if (!e) perf_exp[d] += lat_exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d;
    int         stale;
    logic [3:0] a;
    for (int i = 0; i < NI; i++) begin
      req_valid[i]  = 1'b0;
      resp_ready[i] = 1'b0;
      rounds[i]     = '0;
      st_in[i]      = '0;
      perf_exp[i]   = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_req_ready", req_ready[i], 1);
      check("rst_resp_valid", resp_valid[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_err", err[i], 0);
      check("rst_state", st_out[i], 0);
      check("rst_perf", perf[i], 0);
    end

    run_op(0, 4'd12, '0, 0);
    run_op(0, 4'd12, '0, 0);
    check("perf_two_p12", perf[0], PERF_EN ? 24 : 0);

    run_op(1, 4'd6, rnd320(), 0);
    run_op(1, 4'd8, rnd320(), 0);
    run_op(0, 4'd0, rnd320(), 0);
    run_op(0, 4'd13, rnd320(), 0);
    run_op(2, 4'd6, rnd320(), 0);
    run_op(1, 4'd15, rnd320(), 0);
    run_op(2, 4'd8, rnd320(), 0);
    run_op(1, 4'd4, rnd320(), 5);

    repeat (30) begin
      d = $urandom_range(0, NI - 1);
      a = 4'($urandom_range(0, 15));
      run_op(d, a, rnd320(), $urandom_range(0, 3));
    end

    req_valid[0] = 1'b1;
    rounds[0]    = 4'd12;
    st_in[0]     = rnd320();
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("mid_run_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy[0], 0);
    check("arst_valid", resp_valid[0], 0);
    check("arst_state", st_out[0], 0);
    check("arst_err", err[0], 0);
    check("arst_req_ready", req_ready[0], 1);
    check("arst_perf", perf[0], 0);
    for (int i = 0; i < NI; i++) perf_exp[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (resp_valid[0] || busy[0]) stale++;
    end
    check("no_stale_resp", stale, 0);
    run_op(0, 4'd12, rnd320(), 2);
    run_op(2, 4'd12, rnd320(), 0);

    for (int i = 0; i < NI; i++) begin
      check($sformatf("perf_final_u%0d", UR[i]), perf[i],
            PERF_EN ? perf_exp[i] : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
